// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_IF,
    WAIT_DM,
    DROP_IF
  } arb_state_e;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned STRB_W     = DATA_W_DEF / 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access, with
// data priority bounded by a starvation limit and flush-aware fetch drop.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_valid,
  output logic [DATA_W-1:0]     if_rdata,
  output logic                  if_stall,
  input  logic                  dm_req,
  input  logic [DATA_W/8-1:0]   dm_we,
  input  logic [ADDR_W-1:0]     dm_addr,
  input  logic [DATA_W-1:0]     dm_wdata,
  output logic                  dm_valid,
  output logic [DATA_W-1:0]     dm_rdata,
  output logic                  dm_stall,
  output logic                  mem_req,
  output logic [DATA_W/8-1:0]   mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata
);

  localparam int unsigned     CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             if_ok, sel_dm, sel_if;

  always_comb begin
    if_ok  = if_req && !flush;
    sel_dm = dm_req && !(if_ok && (starve_q == STARVE_LIM));
    sel_if = !sel_dm && if_ok;
  end

  always_comb begin
    mem_we    = sel_dm ? dm_we : '0;
    mem_addr  = sel_dm ? dm_addr : if_addr;
    mem_wdata = dm_wdata;
    if_rdata  = mem_rdata;
    dm_rdata  = mem_rdata;
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    mem_req  = 1'b0;
    if_valid = 1'b0;
    dm_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_req = sel_dm || sel_if;
        if (!if_ok) starve_d = '0;
        if (mem_gnt && sel_dm) begin
          state_d = WAIT_DM;
          if (if_ok && (starve_q != STARVE_LIM)) starve_d = starve_q + CNT_W'(1);
        end else if (mem_gnt && sel_if) begin
          state_d  = WAIT_IF;
          starve_d = '0;
        end
      end
      WAIT_DM: begin
        if (mem_rvalid) begin
          dm_valid = 1'b1;
          state_d  = IDLE;
        end
      end
      WAIT_IF: begin
        // A flush coincident with the response discards it without detouring via DROP_IF.
        if (mem_rvalid) begin
          if_valid = !flush;
          state_d  = IDLE;
        end else if (flush) begin
          state_d = DROP_IF;
        end
      end
      DROP_IF: begin
        if (mem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n) begin
      mem_req  = 1'b0;
      if_valid = 1'b0;
      dm_valid = 1'b0;
    end
  end

  always_comb begin
    if_stall = if_req && !if_valid;
    dm_stall = dm_req && !dm_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

endmodule
